// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - divide controller states, status bit indices and issue decode helper
package div_ctrl_pkg;

  typedef enum logic [2:0] {
    DIV_IDLE = 3'd0,
    DIV_PREP = 3'd1,
    DIV_ITER = 3'd2,
    DIV_FIX  = 3'd3,
    DIV_DONE = 3'd4
  } div_state_e;

  localparam int ST_DZ = 3;
  localparam int ST_V  = 2;
  localparam int ST_N  = 1;
  localparam int ST_Z  = 0;

  localparam int W_DOPC = 8;
  localparam int DDIV   = 3;

  // Decode side: a divide is issued when the slot is valid and the DDIV opcode bit is set.
  function automatic logic div_start(input logic v, input logic [W_DOPC-1:0] dopc);
    return v & dopc[DDIV];
  endfunction

endpackage

// File: rtl/div_ctrl_div_step.sv
// rtl/div_ctrl_div_step.sv - one restoring radix-2 step on the packed {rem, quo} pair
module div_ctrl_div_step #(
  parameter int W_WORD = 32
) (
  input  logic [2*W_WORD-1:0] i_rq,
  input  logic [W_WORD-1:0]   i_divisor,
  output logic [2*W_WORD-1:0] o_rq
);

  logic [W_WORD:0] w_trial;
  logic [W_WORD:0] w_diff;
  logic            w_ge;

  // Shifted remainder needs one extra bit; a set MSB of the difference means a borrow.
  assign w_trial = i_rq[2*W_WORD-1:W_WORD-1];
  assign w_diff  = w_trial - {1'b0, i_divisor};
  assign w_ge    = ~w_diff[W_WORD];

  assign o_rq = w_ge ? {w_diff[W_WORD-1:0], i_rq[W_WORD-2:0], 1'b1}
                     : {w_trial[W_WORD-1:0], i_rq[W_WORD-2:0], 1'b0};

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle signed/unsigned divide controller with decode stall and write-back outputs
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int W_WORD   = 32,
  parameter int W_RD     = 5,
  parameter int W_STATUS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                signed_i,
  input  logic                rem_i,
  input  logic [W_WORD-1:0]   dest_i,
  input  logic [W_WORD-1:0]   src_i,
  input  logic [W_RD-1:0]     rd_name_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [W_RD-1:0]     rd_name_o,
  output logic [W_WORD-1:0]   result_o,
  output logic [W_STATUS-1:0] status_o
);

  localparam int W_CNT = $clog2(W_WORD);

  div_state_e            r_state, w_next;
  logic [W_CNT-1:0]      r_cnt;
  logic [W_WORD-1:0]     r_dend, r_dsor;
  logic                  r_signed, r_rem, r_qneg, r_rneg;
  logic [W_RD-1:0]       r_rd;
  logic [2*W_WORD-1:0]   r_rq, w_rq_next;

  logic                  w_dend_neg, w_dsor_neg, w_is_dz, w_is_ov;
  logic [W_WORD-1:0]     w_abs_dend, w_abs_dsor, w_quo, w_rmd, w_sel;
  logic                  w_load, w_dz, w_v;
  logic [W_STATUS-1:0]   w_status;

  div_ctrl_div_step #(.W_WORD(W_WORD)) u_step (
    .i_rq      (r_rq),
    .i_divisor (r_dsor),
    .o_rq      (w_rq_next)
  );

  assign w_dend_neg = r_signed & r_dend[W_WORD-1];
  assign w_dsor_neg = r_signed & r_dsor[W_WORD-1];
  assign w_abs_dend = w_dend_neg ? -r_dend : r_dend;
  assign w_abs_dsor = w_dsor_neg ? -r_dsor : r_dsor;
  assign w_is_dz    = (r_dsor == '0);
  assign w_is_ov    = r_signed && (r_dend == {1'b1, {(W_WORD-1){1'b0}}}) && (r_dsor == '1);
  assign w_quo      = r_rq[W_WORD-1:0];
  assign w_rmd      = r_rq[2*W_WORD-1:W_WORD];

  assign stall_o = ((r_state == DIV_IDLE) && start_i) || (r_state == DIV_PREP) ||
                   (r_state == DIV_ITER) || (r_state == DIV_FIX);
  assign done_o  = (r_state == DIV_DONE);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_sel  = '0;
    w_dz   = 1'b0;
    w_v    = 1'b0;
    case (r_state)
      DIV_IDLE: if (start_i) w_next = DIV_PREP;
      DIV_PREP: begin
        if (w_is_dz) begin
          w_next = DIV_DONE;
          w_load = 1'b1;
          w_dz   = 1'b1;
          w_sel  = r_rem ? r_dend : '1;
        end else if (w_is_ov) begin
          w_next = DIV_DONE;
          w_load = 1'b1;
          w_v    = 1'b1;
          w_sel  = r_rem ? '0 : r_dend;
        end else begin
          w_next = DIV_ITER;
        end
      end
      DIV_ITER: if (r_cnt == '0) w_next = DIV_FIX;
      DIV_FIX: begin
        w_next = DIV_DONE;
        w_load = 1'b1;
        w_sel  = r_rem ? (r_rneg ? -w_rmd : w_rmd) : (r_qneg ? -w_quo : w_quo);
      end
      DIV_DONE: w_next = DIV_IDLE;
      default:  w_next = DIV_IDLE;
    endcase
    // A flush aborts everything, including the write-back of a result about to complete.
    if (flush_i) begin
      w_next = DIV_IDLE;
      w_load = 1'b0;
    end
  end

  always_comb begin
    w_status        = '0;
    w_status[ST_DZ] = w_dz;
    w_status[ST_V]  = w_v;
    w_status[ST_N]  = w_sel[W_WORD-1];
    w_status[ST_Z]  = (w_sel == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= DIV_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_dend    <= '0;
      r_dsor    <= '0;
      r_signed  <= 1'b0;
      r_rem     <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_rd      <= '0;
      r_rq      <= '0;
      result_o  <= '0;
      status_o  <= '0;
      rd_name_o <= '0;
    end else begin
      if ((r_state == DIV_IDLE) && start_i) begin
        r_dend   <= dest_i;
        r_dsor   <= src_i;
        r_signed <= signed_i;
        r_rem    <= rem_i;
        r_rd     <= rd_name_i;
      end
      if (r_state == DIV_PREP) begin
        r_rq   <= {{W_WORD{1'b0}}, w_abs_dend};
        r_dsor <= w_abs_dsor;
        r_qneg <= w_dend_neg ^ w_dsor_neg;
        r_rneg <= w_dend_neg;
        r_cnt  <= W_CNT'(W_WORD - 1);
      end
      if (r_state == DIV_ITER) begin
        r_rq  <= w_rq_next;
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_load) begin
        result_o  <= w_sel;
        status_o  <= w_status;
        rd_name_o <= r_rd;
      end
    end
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide controller for the execute stage. It accepts one divide operation at a time from the decode/execute boundary and runs an iterative restoring radix-2 divider for `W_WORD` cycles. While it runs, it stalls decode, then presents the quotient or remainder, the status flags and the destination register name for write-back. It fills the execute-stage divide result slot, which is currently constant zero.

## Interface
Parameters:
- `W_WORD`, default 32: operand and result width.
- `W_RD`, default 5: register-name width.
- `W_STATUS`, default 4: status width.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst`: input, 1 bit. Asynchronous, active-low reset.
- `start_i`: input, 1 bit. Valid divide issued; equals `v_i & dopc_i[DDIV]`.
- `signed_i`: input, 1 bit. 1 = signed (DIV), 0 = unsigned (DIVU).
- `rem_i`: input, 1 bit. 1 = return remainder, 0 = return quotient.
- `dest_i`: input, `W_WORD` bits. Dividend.
- `src_i`: input, `W_WORD` bits. Divisor.
- `rd_name_i`: input, `W_RD` bits. Write-back register name.
- `flush_i`: input, 1 bit. Abort the operation in flight (branch taken).
- `stall_o`: output, 1 bit. Hold decode.
- `done_o`: output, 1 bit. One-cycle result-valid pulse.
- `rd_name_o`: output, `W_RD` bits. Latched `rd_name_i`.
- `result_o`: output, `W_WORD` bits. Quotient or remainder.
- `status_o`: output, `W_STATUS` bits. Flags: bit 3 = DZ (divide by zero), bit 2 = V (overflow), bit 1 = N, bit 0 = Z.

## Operation
States: IDLE, PREP, ITER, FIX, DONE.

- **IDLE**
  - On `start_i`: latch operands, `signed_i`, `rem_i` and `rd_name_i`, then go to PREP.
  - Otherwise stay in IDLE.
- **PREP**
  - Form the absolute values of both operands when `signed_i` is set.
  - Record the quotient sign (sign(dest) XOR sign(src)) and the remainder sign (sign(dest)).
  - Clear the partial remainder and load the counter with `W_WORD-1`.
  - Divisor = 0: go to DONE with quotient = all ones, remainder = dividend, DZ=1.
  - Signed, dividend = 2^(W-1) and divisor = all ones: go to DONE with quotient = dividend, remainder = 0, V=1.
  - Otherwise go to ITER.
- **ITER**
  - Each cycle performs one `div_step`: shift {rem, quo} left by 1, trial-subtract the divisor, and set the quotient LSB when the difference is non-negative.
  - The counter decrements each cycle; when it is 0, go to FIX.
- **FIX**
  - Negate the quotient and/or remainder according to the recorded signs (signed only).
  - Select the output via `rem_i`, then go to DONE.
- **DONE**
  - Drive `result_o`, `status_o` and `rd_name_o` with `done_o`=1, then go to IDLE.
  - Status N = `result_o`[W-1] and Z = (`result_o`==0), computed on the selected result, including the special cases.
- **`stall_o`** = `start_i` in IDLE, or state ∈ {PREP, ITER, FIX}. It is 0 in DONE, so decode advances on the edge ending DONE.
- **`start_i` while busy:** ignored. Decode is stalled, so `start_i` in a busy state is a protocol error; the block takes no action.
- **`flush_i`:** has priority over all transitions. Any state goes to IDLE at the next edge, and no `done_o` is produced. `flush_i` and `start_i` together in IDLE: flush wins, so the start is dropped.

## Timing
- **Reset:** state=IDLE, counter=0. Every output is 0: `stall_o`=0, `done_o`=0, `result_o`=0, `status_o`=0, `rd_name_o`=0.
- **Normal latency:** with start sampled in cycle T, PREP is at T+1, ITER at T+2..T+W+1, FIX at T+W+2 and DONE at T+W+3.
  - `done_o`=1 only in cycle T+W+3 (T+35 for W=32).
  - `stall_o`=1 from T through T+W+2.
- **Special cases (divide by zero, overflow):** DONE at T+2; `stall_o`=1 in T and T+1.
- **Output hold:** `result_o`, `status_o` and `rd_name_o` hold their last values after DONE until the next DONE. Consumers qualify them with `done_o`.
- **Back-to-back starts:** `start_i` is accepted in the first IDLE cycle after DONE. There are no dead cycles beyond DONE.
- **Reset mid-operation:** asynchronous return to the reset values, with no pulse.

## Structure
Shared `params.vh` gains:
- state encodings `DIV_IDLE`..`DIV_DONE`, 3 bits;
- status bit indices `ST_DZ`, `ST_V`, `ST_N`, `ST_Z`;
- a `DDIV`-based decode helper for `start_i`.

One combinational sub-module, `div_step`:
- inputs: {rem, quo}, divisor;
- outputs: next {rem, quo}.

The FSM, counter, sign handling and output registers live in `div_ctrl`.

## Test plan
All scenarios use W=32.
- **Unsigned divide:** DIVU 100/7, `rem_i`=0 → `done_o` at T+35, `result_o`=14, `status_o`=0. Repeated with `rem_i`=1 → 2.
- **Signed divide:** DIV −7/2 → quotient 0xFFFFFFFD (−3) with N=1; remainder 0xFFFFFFFF (−1).
- **Divide by zero:** 5/0 with `rem_i`=0 → `done_o` at T+2, `result_o`=0xFFFFFFFF, DZ=1, N=1. With `rem_i`=1 → 5, DZ=1.
- **Signed overflow:** 0x80000000 / 0xFFFFFFFF → `result_o`=0x80000000, V=1, N=1, at T+2. With `rem_i`=1 → 0, Z=1, V=1.
- **Flush mid-operation:** `flush_i` pulsed at T+10 → IDLE at T+11, `stall_o` low from T+11, no `done_o`. A new start at T+12 completes at T+47 with the correct result.
- **Reset and back-to-back:** `rst` low at T+20 → all outputs 0 immediately. Two back-to-back divides with rd 3 then rd 9 → `done_o` at T+35 and T+71, with `rd_name_o` = 3 and 9 respectively and a single-cycle `stall_o` gap.
